// File: rtl/fpm_lane_scheduler.sv
// fpm_lane_scheduler
//   Time-multiplexes one shared fixed-point multiplier (FPM) across the four
//   odd-cosine lanes (C1, C3, C5, C7) of a DCT stage. A 4-sample sign-magnitude
//   vector is accepted over valid/ready, one lane per cycle is issued to the
//   external FPM, the 11-bit products are collected, and the 4-lane result
//   vector is held until the downstream accepts it.
//
// Ports
//   CLK        in   1   clock, rising edge
//   RESET_N    in   1   asynchronous active-low reset
//   IN_VALID   in   1   input vector valid
//   IN_READY   out  1   block can accept a vector (IDLE only)
//   I0..I3     in   12  samples: [11] sign, [10:0] magnitude
//   OUT_VALID  out  1   result vector valid (HOLD only)
//   OUT_READY  in   1   downstream accepts result
//   O0..O3     out  12  results: [11] sample sign, [10:0] product magnitude
//   MUL_A      out  32  FPM operand a: {17'b0, coefficient[14:0]}
//   MUL_B      out  32  FPM operand b: {6'b0, magnitude[10:0], 15'b0}
//   MUL_RES    in   11  FPM product, MUL_LAT cycles after issue
//   BUSY       out  1   high in any state except IDLE

module fpm_lane_scheduler #(
    parameter int unsigned MUL_LAT = 1,
    parameter int unsigned COEF0   = 9808,
    parameter int unsigned COEF1   = 8315,
    parameter int unsigned COEF2   = 5556,
    parameter int unsigned COEF3   = 1951
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [11:0] I0,
    input  logic [11:0] I1,
    input  logic [11:0] I2,
    input  logic [11:0] I3,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [11:0] O0,
    output logic [11:0] O1,
    output logic [11:0] O2,
    output logic [11:0] O3,
    output logic [31:0] MUL_A,
    output logic [31:0] MUL_B,
    input  logic [10:0] MUL_RES,
    output logic        BUSY
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_HOLD
    } state_t;

    localparam logic [2:0] DRAIN_LAST = (MUL_LAT > 0) ? 3'(MUL_LAT - 1) : 3'd0;

    state_t      state, state_nx;
    logic [1:0]  k;
    logic [2:0]  dcnt;
    logic [11:0] smp [4];
    logic [11:0] res [4];
    logic [14:0] coef [4];
    logic        issue_vld;
    logic        cap_vld;
    logic [2:0]  cap_tag;

    assign coef[0] = 15'(COEF0);
    assign coef[1] = 15'(COEF1);
    assign coef[2] = 15'(COEF2);
    assign coef[3] = 15'(COEF3);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= S_IDLE;
            k     <= '0;
            dcnt  <= '0;
            for (int unsigned i = 0; i < 4; i++) smp[i] <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && IN_VALID) begin
                smp[0] <= I0;
                smp[1] <= I1;
                smp[2] <= I2;
                smp[3] <= I3;
            end
            // k returns to 0 on the last issue cycle, the same edge that leaves ISSUE
            k    <= (state == S_ISSUE) ? k + 2'd1 : '0;
            dcnt <= (state == S_DRAIN) ? dcnt + 3'd1 : '0;
        end
    end

    always_comb begin
        state_nx  = state;
        IN_READY  = 1'b0;
        OUT_VALID = 1'b0;
        BUSY      = 1'b1;
        MUL_A     = '0;
        MUL_B     = '0;
        issue_vld = 1'b0;
        case (state)
            S_IDLE: begin
                IN_READY = 1'b1;
                BUSY     = 1'b0;
                if (IN_VALID) state_nx = S_ISSUE;
            end
            S_ISSUE: begin
                issue_vld = 1'b1;
                MUL_A     = {17'd0, coef[k]};
                MUL_B     = {6'd0, smp[k][10:0], 15'd0};
                if (k == 2'd3) state_nx = (MUL_LAT > 0) ? S_DRAIN : S_HOLD;
            end
            S_DRAIN: begin
                if (dcnt == DRAIN_LAST) state_nx = S_HOLD;
            end
            S_HOLD: begin
                OUT_VALID = 1'b1;
                if (OUT_READY) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Lane tag travels alongside the multiplier so each product lands in its own lane.
    generate
        if (MUL_LAT == 0) begin : g_comb
            assign cap_vld = issue_vld;
            assign cap_tag = {1'b0, k};
        end else begin : g_pipe
            logic [3:0] pipe [MUL_LAT];
            always_ff @(posedge CLK or negedge RESET_N) begin
                if (!RESET_N) begin
                    for (int unsigned i = 0; i < MUL_LAT; i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= {issue_vld, 1'b0, k};
                    for (int unsigned i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
                end
            end
            assign cap_vld = pipe[MUL_LAT-1][3];
            assign cap_tag = pipe[MUL_LAT-1][2:0];
        end
    endgenerate

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int unsigned i = 0; i < 4; i++) res[i] <= '0;
        end else if (cap_vld && !cap_tag[2]) begin
            res[cap_tag[1:0]] <= {smp[cap_tag[1:0]][11], MUL_RES};
        end
    end

    assign O0 = res[0];
    assign O1 = res[1];
    assign O2 = res[2];
    assign O3 = res[3];

endmodule
